// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file for the MIPS datapath.
//
// Two combinational read ports, two write (retire) lanes, an I/O register
// slot and a per-register busy scoreboard for the hazard unit.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   raddr1/2 -> rdata1/2    combinational read data (optional write bypass)
//   rbusy1/2                busy bit of the register addressed by raddr1/2
//   we_a/waddr_a/wdata_a    retire lane A (older instruction)
//   we_b/waddr_b/wdata_b    retire lane B (younger instruction, wins ties)
//   issue_v/issue_addr      marks a destination register busy
//   io_we/io_in             loads external data into register IOREG
//   io_out                  stored contents of IOREG
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int IOREG    = 30,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic             rbusy1,
    output logic             rbusy2,
    input  logic             we_a,
    input  logic [AW-1:0]    waddr_a,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic             we_b,
    input  logic [AW-1:0]    waddr_b,
    input  logic [WIDTH-1:0] wdata_b,
    input  logic             issue_v,
    input  logic [AW-1:0]    issue_addr,
    input  logic             io_we,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out
);

    localparam int            DEPTH   = 2 ** AW;
    localparam logic [AW-1:0] IO_ADDR = AW'(IOREG);

    logic [WIDTH-1:0] mem_reg  [DEPTH];
    logic [WIDTH-1:0] mem_next [DEPTH];
    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    // Per-register next-state: lane B beats lane A beats the I/O load.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign mem_next[gi]  = '0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_norm
                localparam logic [AW-1:0] IDX = AW'(gi);
                logic hit_a;
                logic hit_b;
                logic hit_io;
                logic hit_issue;

                assign hit_a     = we_a && (waddr_a == IDX);
                assign hit_b     = we_b && (waddr_b == IDX);
                assign hit_io    = io_we && (IDX == IO_ADDR);
                assign hit_issue = issue_v && (issue_addr == IDX);

                assign mem_next[gi] = hit_b  ? wdata_b :
                                      hit_a  ? wdata_a :
                                      hit_io ? io_in   : mem_reg[gi];

                // A new issue outranks a retire of the previous producer.
                assign busy_next[gi] = hit_issue ? 1'b1 :
                                       (hit_a || hit_b) ? 1'b0 : busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            mem_reg  <= mem_next;
            busy_reg <= busy_next;
        end
    end

    // Read ports: storage, optionally overridden by a same-cycle write using
    // the same priority as the commit; register 0 masks everything last.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [AW-1:0]    addr;
            logic [WIDTH-1:0] data;

            assign addr = (gi == 0) ? raddr1 : raddr2;

            always_comb begin
                data = mem_reg[addr];
                if (BYPASS != 0) begin
                    if (we_b && (waddr_b == addr)) begin
                        data = wdata_b;
                    end else if (we_a && (waddr_a == addr)) begin
                        data = wdata_a;
                    end else if (io_we && (addr == IO_ADDR)) begin
                        data = io_in;
                    end
                end
                if (ZERO_REG != 0 && addr == '0) begin
                    data = '0;
                end
            end
        end
    endgenerate

    assign rdata1 = g_rd[0].data;
    assign rdata2 = g_rd[1].data;
    assign rbusy1 = busy_reg[raddr1];
    assign rbusy2 = busy_reg[raddr2];
    assign io_out = mem_reg[IOREG];

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp. Expected values are pushed onto a queue when the
// stimulus is driven and popped when the corresponding output is sampled.
// Inputs change just after the falling edge; outputs are sampled 2 ns later,
// well clear of the rising edge.
module tb_regfile_mp;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [AW-1:0]    raddr1, raddr2;
    logic [WIDTH-1:0] rdata1, rdata2;
    logic             rbusy1, rbusy2;
    logic             we_a, we_b;
    logic [AW-1:0]    waddr_a, waddr_b;
    logic [WIDTH-1:0] wdata_a, wdata_b;
    logic             issue_v;
    logic [AW-1:0]    issue_addr;
    logic             io_we;
    logic [WIDTH-1:0] io_in;
    logic [WIDTH-1:0] io_out;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp;

    always #5 clk = ~clk;

    regfile_mp #(
        .WIDTH(WIDTH), .AW(AW), .IOREG(30), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
        .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
        .issue_v(issue_v), .issue_addr(issue_addr),
        .io_we(io_we), .io_in(io_in), .io_out(io_out)
    );

    task automatic idle();
        we_a = 0; we_b = 0; issue_v = 0; io_we = 0;
        waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
        issue_addr = '0; io_in = '0;
    endtask

    task automatic test_reset();
        idle();
        raddr1 = '0; raddr2 = '0;
        reset_n = 0;
        repeat (2) @(negedge clk);
        #2;
        exp_q.push_back(32'd0);
        exp = exp_q.pop_front(); checks++;
        if (io_out !== exp) begin failures++; $display("FAIL reset_io_out_low got=%h exp=%h", io_out, exp); end
        reset_n = 1;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            raddr1 = AW'(a); raddr2 = AW'(31 - a);
            exp_q.push_back(32'd0); exp_q.push_back(32'd0);
            exp_q.push_back(32'd0); exp_q.push_back(32'd0);
            #2;
            exp = exp_q.pop_front(); checks++;
            if (rdata1 !== exp) begin failures++; $display("FAIL reset_rdata1 addr=%0d got=%h exp=%h", a, rdata1, exp); end
            exp = exp_q.pop_front(); checks++;
            if (rdata2 !== exp) begin failures++; $display("FAIL reset_rdata2 addr=%0d got=%h exp=%h", 31 - a, rdata2, exp); end
            exp = exp_q.pop_front(); checks++;
            if ({31'd0, rbusy1} !== exp) begin failures++; $display("FAIL reset_rbusy1 addr=%0d got=%b exp=%0d", a, rbusy1, exp); end
            exp = exp_q.pop_front(); checks++;
            if ({31'd0, rbusy2} !== exp) begin failures++; $display("FAIL reset_rbusy2 addr=%0d got=%b exp=%0d", 31 - a, rbusy2, exp); end
        end
        exp_q.push_back(32'd0);
        exp = exp_q.pop_front(); checks++;
        if (io_out !== exp) begin failures++; $display("FAIL reset_io_out got=%h exp=%h", io_out, exp); end
        $display("tb: reset and read-all done");
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        we_a = 1; waddr_a = 5; wdata_a = 32'h11111111;
        we_b = 1; waddr_b = 7; wdata_b = 32'h22222222;
        exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
        @(negedge clk);
        idle();
        raddr1 = 5; raddr2 = 7;
        #2;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL dual_write_r5 got=%h exp=%h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata2 !== exp) begin failures++; $display("FAIL dual_write_r7 got=%h exp=%h", rdata2, exp); end
        $display("tb: dual write r5/r7 done");
    endtask

    task automatic test_conflict_bypass();
        @(negedge clk);
        we_a = 1; waddr_a = 9; wdata_a = 32'hAAAA0000;
        we_b = 1; waddr_b = 9; wdata_b = 32'hBBBB0000;
        raddr1 = 9; raddr2 = 7;
        exp_q.push_back(32'hBBBB0000); exp_q.push_back(32'h22222222);
        #2;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL conflict_bypass got=%h exp=%h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata2 !== exp) begin failures++; $display("FAIL conflict_other_port got=%h exp=%h", rdata2, exp); end
        exp_q.push_back(32'hBBBB0000);
        @(negedge clk);
        idle();
        #2;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL conflict_stored got=%h exp=%h", rdata1, exp); end
        // Lane A alone bypasses over the stored value.
        @(negedge clk);
        we_a = 1; waddr_a = 9; wdata_a = 32'h0000CAFE;
        exp_q.push_back(32'h0000CAFE);
        #2;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL lane_a_bypass got=%h exp=%h", rdata1, exp); end
        @(negedge clk);
        idle();
        $display("tb: write conflict and bypass done");
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we_a = 1; waddr_a = 0; wdata_a = 32'hDEADBEEF;
        issue_v = 1; issue_addr = 0;
        raddr1 = 0;
        exp_q.push_back(32'd0);
        #2;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL zero_bypass got=%h exp=%h", rdata1, exp); end
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        @(negedge clk);
        idle();
        #2;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL zero_stored got=%h exp=%h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, rbusy1} !== exp) begin failures++; $display("FAIL zero_busy got=%b exp=%0d", rbusy1, exp); end
        $display("tb: zero register done");
    endtask

    task automatic test_io_reg();
        @(negedge clk);
        io_we = 1; io_in = 32'h12345678;
        raddr1 = 30;
        exp_q.push_back(32'h12345678); exp_q.push_back(32'd0);
        #2;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL io_read_bypass got=%h exp=%h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (io_out !== exp) begin failures++; $display("FAIL io_out_no_bypass got=%h exp=%h", io_out, exp); end
        exp_q.push_back(32'h12345678);
        @(negedge clk);
        idle();
        #2;
        exp = exp_q.pop_front(); checks++;
        if (io_out !== exp) begin failures++; $display("FAIL io_out_load got=%h exp=%h", io_out, exp); end
        @(negedge clk);
        io_we = 1; io_in = 32'h1;
        we_a = 1; waddr_a = 30; wdata_a = 32'h2;
        exp_q.push_back(32'h2); exp_q.push_back(32'h2);
        @(negedge clk);
        idle();
        #2;
        exp = exp_q.pop_front(); checks++;
        if (io_out !== exp) begin failures++; $display("FAIL io_out_lane_priority got=%h exp=%h", io_out, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL io_rdata_lane_priority got=%h exp=%h", rdata1, exp); end
        $display("tb: io register done");
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue_v = 1; issue_addr = 12;
        raddr1 = 12;
        exp_q.push_back(32'd0);
        #2;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, rbusy1} !== exp) begin failures++; $display("FAIL busy_before_edge got=%b exp=%0d", rbusy1, exp); end
        exp_q.push_back(32'd1);
        @(negedge clk);
        idle();
        #2;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, rbusy1} !== exp) begin failures++; $display("FAIL busy_set got=%b exp=%0d", rbusy1, exp); end
        @(negedge clk);
        we_b = 1; waddr_b = 12; wdata_b = 32'h33;
        issue_v = 1; issue_addr = 12;
        exp_q.push_back(32'd1); exp_q.push_back(32'h33);
        @(negedge clk);
        idle();
        #2;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, rbusy1} !== exp) begin failures++; $display("FAIL busy_set_wins got=%b exp=%0d", rbusy1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL busy_reg12_data got=%h exp=%h", rdata1, exp); end
        @(negedge clk);
        we_a = 1; waddr_a = 12; wdata_a = 32'h44;
        exp_q.push_back(32'd1);
        #2;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, rbusy1} !== exp) begin failures++; $display("FAIL busy_clear_not_forwarded got=%b exp=%0d", rbusy1, exp); end
        exp_q.push_back(32'd0);
        @(negedge clk);
        idle();
        #2;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, rbusy1} !== exp) begin failures++; $display("FAIL busy_clear got=%b exp=%0d", rbusy1, exp); end
        $display("tb: scoreboard done");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        issue_v = 1; issue_addr = 13;
        raddr2 = 13;
        exp_q.push_back(32'd1);
        @(negedge clk);
        idle();
        #2;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, rbusy2} !== exp) begin failures++; $display("FAIL mid_busy_before got=%b exp=%0d", rbusy2, exp); end
        // Assert reset mid-cycle while a write to r13 is pending.
        we_a = 1; waddr_a = 13; wdata_a = 32'h55;
        raddr1 = 13;
        #1;
        reset_n = 0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'h55);
        #1;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, rbusy2} !== exp) begin failures++; $display("FAIL mid_busy_cleared got=%b exp=%0d", rbusy2, exp); end
        exp = exp_q.pop_front(); checks++;
        if (io_out !== exp) begin failures++; $display("FAIL mid_io_out got=%h exp=%h", io_out, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL mid_rdata_bypass got=%h exp=%h", rdata1, exp); end
        @(negedge clk);
        idle();
        reset_n = 1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        @(negedge clk);
        #2;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL mid_write_discarded got=%h exp=%h", rdata1, exp); end
        raddr1 = 9;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin failures++; $display("FAIL mid_r9_cleared got=%h exp=%h", rdata1, exp); end
        $display("tb: mid-operation reset done");
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_conflict_bypass();
        test_zero_reg();
        test_io_reg();
        test_scoreboard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the MIPS datapath; successor of the 32x32 two-read/one-write file.
- Adds a second write port, optional write-through bypass, a hardwired-zero register, and a memory-mapped I/O register slot.
- Adds a per-register busy scoreboard for the pipeline hazard unit.
- Sits between decode (reads, issue) and writeback (two retire lanes).

Parameters:
- WIDTH, 32, data width in bits.
- AW, 5, address width; DEPTH = 2**AW registers.
- IOREG, 30, index of the I/O register exposed on io_in/io_out.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to the read data.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- raddr1  in  AW  read port 1 address.
- raddr2  in  AW  read port 2 address.
- rdata1  out  WIDTH  read port 1 data.
- rdata2  out  WIDTH  read port 2 data.
- rbusy1  out  1  busy bit of raddr1.
- rbusy2  out  1  busy bit of raddr2.
- we_a  in  1  write enable, lane A (older instruction).
- waddr_a  in  AW  write address, lane A.
- wdata_a  in  WIDTH  write data, lane A.
- we_b  in  1  write enable, lane B (younger instruction).
- waddr_b  in  AW  write address, lane B.
- wdata_b  in  WIDTH  write data, lane B.
- issue_v  in  1  mark issue_addr busy.
- issue_addr  in  AW  destination register being issued.
- io_we  in  1  load io_in into register IOREG.
- io_in  in  WIDTH  external data for IOREG.
- io_out  out  WIDTH  registered contents of IOREG.

Behaviour:
- Reset: reset_n low asynchronously clears every register and every busy bit to 0. io_out = 0 and rbusy1/2 = 0 while reset_n is low. rdata1/2 read 0, or bypass data when BYPASS=1 and a write enable is active. Reset asserted mid-operation discards any write in that cycle.
- Storage: DEPTH x WIDTH flops, updated on the rising edge of clk.
- Write priority to the same address in one cycle, highest first: lane B, then lane A, then io_we. Lower-priority writes to the same address are dropped. Writes to distinct addresses all commit.
- io_we affects only IOREG. Lanes A/B may also write IOREG under the priority above.
- Reads are combinational from storage (0-cycle latency); the new value is visible in storage the cycle after the write.
- BYPASS=1:
  - If raddrN matches an enabled write this cycle, rdataN returns that write data, using the same priority (B > A > io).
  - io bypass applies only when raddrN == IOREG.
- BYPASS=0: reads return pre-edge storage only.
- ZERO_REG=1:
  - Writes to address 0 from any source are discarded.
  - rdataN = 0 for address 0, including under bypass.
  - issue to address 0 is ignored.
- io_out reflects stored IOREG (post-edge), with no bypass.
- Scoreboard, one busy bit per register:
  - issue_v sets busy[issue_addr] at the clock edge.
  - we_a or we_b clears busy[waddr] at the edge.
  - Set and clear of the same register in the same cycle: set wins (the new producer is outstanding).
  - io_we does not affect busy.
- rbusyN = busy[raddrN], combinational from state. A clear in the current cycle is not forwarded; it is visible next cycle.
- Addresses ≥ DEPTH cannot occur, since AW bits span DEPTH exactly.
- Unknown or X enables are not supported; the bench drives known values.

Test Plan:
- Reset then read: reset_n=0 for 2 cycles, release; read all 32 addresses -> rdata=0, rbusy=0, io_out=0.
- Dual write, distinct addresses: we_a waddr_a=5 wdata_a=0x11111111, we_b waddr_b=7 wdata_b=0x22222222; next cycle raddr1=5, raddr2=7 -> 0x11111111 / 0x22222222.
- Conflict and bypass: we_a and we_b both to reg 9 (0xAAAA0000 / 0xBBBB0000), raddr1=9 in the same cycle -> rdata1=0xBBBB0000 same cycle (BYPASS=1) and after the edge.
- Zero register: we_a waddr_a=0 wdata_a=0xDEADBEEF and issue_addr=0 -> rdata for address 0 reads 0, rbusy=0.
- I/O register:
  - io_we io_in=0x12345678 -> io_out=0x12345678 next cycle.
  - Simultaneous io_we io_in=0x1 with we_a waddr_a=30 wdata_a=0x2 -> io_out=0x2.
- Scoreboard:
  - issue_v issue_addr=12 -> rbusy for reg 12 = 1 next cycle.
  - Later we_b waddr_b=12 with issue_v issue_addr=12 in the same cycle -> reg 12 still busy.
  - A subsequent we_a to reg 12 alone -> rbusy=0.
  - Assert reset_n=0 mid-sequence -> all busy bits clear immediately.
